// File: rtl/ethernet_head_parser.sv
// Ethernet RX header parser: collects the first 42 bytes of each frame from
// the 64-bit MAC stream and flags ARP requests, ICMP echo requests and UDP
// datagrams addressed to this FPGA. The result is a one-cycle pulse that
// feeds the reply header builder.
module ethernet_head_parser #(
  parameter logic [47:0] FPGA_MAC     = 48'h211abcdef112,
  parameter logic [31:0] FPGA_IP      = 32'hC0000186,
  parameter logic [15:0] UDP_port_dst = 16'h0000
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [63:0]  i_data,
  input  logic [7:0]   i_keep,
  input  logic         i_valid,
  input  logic         i_last,
  output logic [335:0] o_data_head,
  output logic         o_data_head_valid,
  output logic         o_arp_valid,
  output logic         o_icmp_valid,
  output logic         o_udp_valid,
  output logic         o_drop
);

  typedef enum logic [1:0] {IDLE, HEAD, SKIP} state_t;

  state_t         state;
  logic [2:0]     count;
  logic [319:0]   head_buf;
  logic [335:0]   cand;
  logic           head_ok;

  logic [47:0]    dst_mac;
  logic [15:0]    ethertype;
  logic [15:0]    arp_oper;
  logic [31:0]    arp_tpa;
  logic [7:0]     ip_ver_ihl;
  logic [7:0]     ip_proto;
  logic [31:0]    ip_dst;
  logic [7:0]     icmp_type;
  logic [15:0]    udp_dport;
  logic           mac_ok;
  logic           ipv4_to_us;
  logic           is_arp;
  logic           is_icmp;
  logic           is_udp;
  logic           unused_keep;

  // Only the top two byte enables of beat 5 matter; the rest are ignored.
  assign unused_keep = ^i_keep[5:0];

  // Candidate header: bytes 0..39 already stored plus bytes 40..41 of beat 5.
  assign cand    = {head_buf, i_data[63:48]};
  assign head_ok = (i_keep[7:6] == 2'b11);

  // Field extraction; frame byte k lives at cand[(42-k)*8-1 -: 8].
  assign dst_mac    = cand[335:288];
  assign ethertype  = cand[239:224];
  assign ip_ver_ihl = cand[223:216];
  assign arp_oper   = cand[175:160];
  assign ip_proto   = cand[151:144];
  assign ip_dst     = cand[95:64];
  assign icmp_type  = cand[63:56];
  assign udp_dport  = cand[47:32];
  assign arp_tpa    = cand[31:0];

  assign mac_ok     = (dst_mac == FPGA_MAC) || (dst_mac == 48'hFFFFFFFFFFFF);
  assign ipv4_to_us = (ethertype == 16'h0800) && (ip_ver_ihl == 8'h45) &&
                      (ip_dst == FPGA_IP);
  assign is_arp     = mac_ok && (ethertype == 16'h0806) &&
                      (arp_oper == 16'h0001) && (arp_tpa == FPGA_IP);
  assign is_icmp    = mac_ok && ipv4_to_us && (ip_proto == 8'h01) &&
                      (icmp_type == 8'h08);
  assign is_udp     = mac_ok && ipv4_to_us && (ip_proto == 8'h11) &&
                      (udp_dport == UDP_port_dst);

  // Frame tracking FSM: store beats 0..4, finish on beat 5, then skip payload.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state             <= IDLE;
      count             <= 3'd0;
      head_buf          <= '0;
      o_data_head       <= '0;
      o_data_head_valid <= 1'b0;
      o_arp_valid       <= 1'b0;
      o_icmp_valid      <= 1'b0;
      o_udp_valid       <= 1'b0;
      o_drop            <= 1'b0;
    end else begin
      o_data_head_valid <= 1'b0;
      o_arp_valid       <= 1'b0;
      o_icmp_valid      <= 1'b0;
      o_udp_valid       <= 1'b0;
      o_drop            <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            head_buf[319:256] <= i_data;
            if (i_last) begin
              o_drop <= 1'b1;
            end else begin
              state <= HEAD;
              count <= 3'd1;
            end
          end
        end
        HEAD: begin
          if (i_valid) begin
            if (count == 3'd5) begin
              count <= 3'd0;
              if (head_ok) begin
                o_data_head       <= cand;
                o_data_head_valid <= 1'b1;
                o_arp_valid       <= is_arp;
                o_icmp_valid      <= is_icmp;
                o_udp_valid       <= is_udp;
                state             <= i_last ? IDLE : SKIP;
              end else if (i_last) begin
                o_drop <= 1'b1;
                state  <= IDLE;
              end else begin
                state <= SKIP;
              end
            end else begin
              case (count)
                3'd1:    head_buf[255:192] <= i_data;
                3'd2:    head_buf[191:128] <= i_data;
                3'd3:    head_buf[127:64]  <= i_data;
                3'd4:    head_buf[63:0]    <= i_data;
                default: ;
              endcase
              if (i_last) begin
                o_drop <= 1'b1;
                state  <= IDLE;
                count  <= 3'd0;
              end else begin
                count <= count + 3'd1;
              end
            end
          end
        end
        SKIP: begin
          if (i_valid && i_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_head_parser.sv
// Self-checking bench for ethernet_head_parser: directed frames from the
// test plan followed by randomized frames, all compared against a byte-level
// reference model and an expected-event queue.
module tb_ethernet_head_parser;

  localparam logic [47:0] FPGA_MAC     = 48'h211abcdef112;
  localparam logic [31:0] FPGA_IP      = 32'hC0000186;
  localparam logic [15:0] UDP_port_dst = 16'h0000;

  logic         i_clk;
  logic         i_reset_n;
  logic [63:0]  i_data;
  logic [7:0]   i_keep;
  logic         i_valid;
  logic         i_last;
  logic [335:0] o_data_head;
  logic         o_data_head_valid;
  logic         o_arp_valid;
  logic         o_icmp_valid;
  logic         o_udp_valid;
  logic         o_drop;

  ethernet_head_parser #(
    .FPGA_MAC(FPGA_MAC),
    .FPGA_IP(FPGA_IP),
    .UDP_port_dst(UDP_port_dst)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_data(i_data),
    .i_keep(i_keep),
    .i_valid(i_valid),
    .i_last(i_last),
    .o_data_head(o_data_head),
    .o_data_head_valid(o_data_head_valid),
    .o_arp_valid(o_arp_valid),
    .o_icmp_valid(o_icmp_valid),
    .o_udp_valid(o_udp_valid),
    .o_drop(o_drop)
  );

  typedef struct {
    int           cyc;
    logic         is_head;
    logic [2:0]   flags;
    logic [335:0] head;
  } ev_t;

  ev_t          evq[$];
  int           checks = 0;
  int           fails  = 0;
  int           cyc    = 0;
  logic [7:0]   frame[0:127];
  int           frame_len;
  logic [335:0] model_head = '0;

  // Free-running clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Count active edges so expected pulse times can be expressed in cycles
  always @(posedge i_clk) cyc <= cyc + 1;

  // Single comparison point: counts every check, reports any mismatch
  task automatic checkOutput(input string tag, input logic [335:0] observed,
                             input logic [335:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference classification computed straight from the frame bytes
  function automatic logic [2:0] model_flags();
    logic [47:0] mac;
    logic        mac_ok, ip_ok, arp, icmp, udp;
    mac    = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
    mac_ok = (mac == FPGA_MAC) || (mac == 48'hFFFFFFFFFFFF);
    ip_ok  = ({frame[12], frame[13]} == 16'h0800) && (frame[14] == 8'h45) &&
             ({frame[30], frame[31], frame[32], frame[33]} == FPGA_IP);
    arp    = mac_ok && ({frame[12], frame[13]} == 16'h0806) &&
             ({frame[20], frame[21]} == 16'h0001) &&
             ({frame[38], frame[39], frame[40], frame[41]} == FPGA_IP);
    icmp   = mac_ok && ip_ok && (frame[23] == 8'h01) && (frame[34] == 8'h08);
    udp    = mac_ok && ip_ok && (frame[23] == 8'h11) &&
             ({frame[36], frame[37]} == UDP_port_dst);
    return {arp, icmp, udp};
  endfunction

  // Reference header: frame byte k at bits [(42-k)*8-1 -: 8]
  function automatic logic [335:0] model_header();
    logic [335:0] h;
    h = '0;
    for (int k = 0; k < 42; k++) h[(42-k)*8-1 -: 8] = frame[k];
    return h;
  endfunction

  // Write an n-byte big-endian field into the frame buffer
  task automatic put_field(input int off, input int n, input logic [47:0] v);
    for (int i = 0; i < n; i++) frame[off+i] = v[8*(n-1-i) +: 8];
  endtask

  // Build a frame of the given kind: 0 ARP, 1 ICMP, 2 UDP, 3 UDP wrong
  // port, 4 random bytes, 5 ICMP to a foreign unicast MAC
  task automatic build_frame(input int kind, input int len);
    frame_len = len;
    for (int i = 0; i < 128; i++) frame[i] = 8'($urandom);
    if (kind == 0) put_field(0, 6, 48'hFFFFFFFFFFFF);
    else if (kind == 5) put_field(0, 6, 48'h020000000001);
    else put_field(0, 6, ($urandom_range(0, 1) == 1) ? FPGA_MAC : 48'hFFFFFFFFFFFF);
    case (kind)
      0: begin
        put_field(12, 2, 48'h0806);
        put_field(20, 2, 48'h0001);
        put_field(38, 4, {16'h0, FPGA_IP});
      end
      1, 5: begin
        put_field(12, 2, 48'h0800);
        frame[14] = 8'h45;
        frame[23] = 8'h01;
        put_field(30, 4, {16'h0, FPGA_IP});
        frame[34] = 8'h08;
      end
      2, 3: begin
        put_field(12, 2, 48'h0800);
        frame[14] = 8'h45;
        frame[23] = 8'h11;
        put_field(30, 4, {16'h0, FPGA_IP});
        put_field(36, 2, (kind == 2) ? {32'h0, UDP_port_dst} : 48'h1234);
      end
      default: ;
    endcase
  endtask

  // Drive the current frame; optional idle gap before gap_beat and optional
  // reset assertion on rst_beat (which aborts the frame)
  task automatic applyStimulus(input int gap_beat, input int gap_len, input int rst_beat);
    int         nbeats;
    logic [63:0] d;
    logic [7:0]  k;
    ev_t        ev;
    nbeats = (frame_len + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          i_valid = 1'b0;
          i_data  = {$urandom, $urandom};
          i_keep  = 8'($urandom);
          i_last  = 1'($urandom);
          @(negedge i_clk);
        end
      end
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < frame_len) begin
          d[63-8*j -: 8] = frame[8*b + j];
          k[7-j]         = 1'b1;
        end else begin
          d[63-8*j -: 8] = 8'h00;
          k[7-j]         = 1'b0;
        end
      end
      i_data  = d;
      i_keep  = k;
      i_valid = 1'b1;
      i_last  = (b == nbeats - 1);
      if (b == rst_beat) begin
        i_reset_n = 1'b0;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        return;
      end
      if (frame_len >= 42 && b == 5) begin
        ev.cyc = cyc + 1; ev.is_head = 1'b1;
        ev.flags = model_flags(); ev.head = model_header();
        evq.push_back(ev);
      end else if (frame_len < 42 && b == nbeats - 1) begin
        ev.cyc = cyc + 1; ev.is_head = 1'b0;
        ev.flags = 3'b000; ev.head = '0;
        evq.push_back(ev);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic idleCycles(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  // Monitor: every cycle compare outputs against the event queue and model
  always @(negedge i_clk) begin
    ev_t ev;
    #1;
    if (!i_reset_n) begin
      model_head = '0;
      checkOutput("reset_head", o_data_head, '0);
      checkOutput("reset_pulses", 336'({o_data_head_valid, o_arp_valid, o_icmp_valid,
                                        o_udp_valid, o_drop}), '0);
    end else if (o_data_head_valid || o_drop) begin
      if (evq.size() == 0) begin
        checkOutput("unexpected_pulse", 336'({o_data_head_valid, o_drop}), '0);
      end else begin
        ev = evq.pop_front();
        checkOutput("pulse_cycle", 336'(cyc), 336'(ev.cyc));
        checkOutput("pulse_kind", 336'({o_data_head_valid, o_drop}),
                    ev.is_head ? 336'(2'b10) : 336'(2'b01));
        checkOutput("class_flags", 336'({o_arp_valid, o_icmp_valid, o_udp_valid}),
                    336'(ev.flags));
        if (ev.is_head) model_head = ev.head;
        checkOutput("head_value", o_data_head, model_head);
      end
    end else begin
      if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        checkOutput("missing_pulse", 336'({o_data_head_valid, o_drop}),
                    ev.is_head ? 336'(2'b10) : 336'(2'b01));
      end
      checkOutput("idle_flags", 336'({o_arp_valid, o_icmp_valid, o_udp_valid}), '0);
      checkOutput("head_hold", o_data_head, model_head);
    end
  end

  // Main sequence: directed frames from the test plan, then random traffic
  initial begin
    i_reset_n = 1'b0;
    i_data    = '0;
    i_keep    = '0;
    i_valid   = 1'b0;
    i_last    = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    $display("[TB] directed frames");
    build_frame(0, 60);  applyStimulus(-1, 0, -1); idleCycles(2);
    build_frame(1, 98);  applyStimulus(-1, 0, -1); idleCycles(2);
    build_frame(2, 64);  applyStimulus(-1, 0, -1); idleCycles(2);
    build_frame(3, 64);  applyStimulus(-1, 0, -1); idleCycles(2);
    build_frame(1, 40);  applyStimulus(-1, 0, -1); idleCycles(2);
    build_frame(0, 41);  applyStimulus(-1, 0, -1); idleCycles(2);
    build_frame(0, 42);  applyStimulus(-1, 0, -1);
    build_frame(1, 70);  applyStimulus(3, 3, -1);  idleCycles(2);
    build_frame(2, 64);  applyStimulus(-1, 0, 3);
    build_frame(2, 64);  applyStimulus(-1, 0, -1); idleCycles(2);

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      int kind, len, nb, gb;
      kind = $urandom_range(0, 5);
      len  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 41) : $urandom_range(42, 100);
      build_frame(kind, len);
      nb = (len + 7) / 8;
      gb = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nb - 1) : -1;
      applyStimulus(gb, $urandom_range(1, 3), -1);
      idleCycles($urandom_range(0, 2));
    end

    idleCycles(4);
    checkOutput("events_drained", 336'(evq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
